// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, the decoded
// instruction record and the combinational decode/immediate helpers.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // FMT_X marks an opcode outside RV32I.
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        writes_rd;
    logic        uses_rs1;
    logic        uses_rs2;
  } decoded_t;

  function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_STORE:                      fmt = FMT_S;
      OPC_OP:                         fmt = FMT_R;
      default:                        fmt = FMT_X;
    endcase
    return fmt;
  endfunction

  // Sign-extended 32-bit immediate; R-type and unknown formats yield zero.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm = {i[31:12], 12'h000};
      FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

  function automatic decoded_t decode(input logic [31:0] i);
    decoded_t d;
    imm_fmt_e fmt;
    fmt         = fmt_of(i[6:0]);
    d.opcode    = i[6:0];
    d.funct3    = i[14:12];
    d.funct7    = i[31:25];
    d.rd        = i[11:7];
    d.rs1       = i[19:15];
    d.rs2       = i[24:20];
    d.imm       = imm_gen(i, fmt);
    d.illegal   = (fmt == FMT_X);
    d.writes_rd = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
    d.uses_rs1  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    d.uses_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set when an
// rd-writing instruction issues downstream, cleared by writeback. Set wins
// over a same-cycle clear; register 0 is never marked busy.
import riscv_pkg::*;

module scoreboard #(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_next;

  // Apply clear first so that a simultaneous set of the same bit prevails.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/decode_issue.sv
// Single-entry decode/issue stage: decodes the fetched instruction, reads
// operands, blocks on RAW hazards against the scoreboard and the held entry,
// and hands one instruction per cycle to the downstream stage.
import riscv_pkg::*;

module decode_issue #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic [$clog2(NREG)-1:0] rf_addr_a,
  output logic [$clog2(NREG)-1:0] rf_addr_b,
  input  logic [XLEN-1:0]         rf_a,
  input  logic [XLEN-1:0]         rf_b,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [$clog2(NREG)-1:0] out_rd,
  output logic [XLEN-1:0]         out_rs1_val,
  output logic [XLEN-1:0]         out_rs2_val,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_pc,
  output logic                    out_illegal
);

  localparam int AW = $clog2(NREG);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]             state, state_next;
  logic                   full, accept, handoff, hazard, hit_a, hit_b;
  logic                   out_wr;
  logic [NREG-1:0]        busy;
  logic [AW-1:0]          rs1, rs2, rd;
  logic signed [XLEN-1:0] imm_ext;
  decoded_t               dec;

  assign dec       = decode(in_instr[31:0]);
  assign rs1       = dec.rs1[AW-1:0];
  assign rs2       = dec.rs2[AW-1:0];
  assign rd        = dec.rd[AW-1:0];
  assign imm_ext   = $signed(dec.imm);
  assign rf_addr_a = rs1;
  assign rf_addr_b = rs2;

  assign full      = (state == ST_FULL);
  assign out_valid = full;

  // A source hits if it is pending in the scoreboard or is produced by the
  // entry still sitting in this stage; writeback is not bypassed.
  assign hit_a  = dec.uses_rs1 && (rs1 != '0) &&
                  (busy[rs1] || (full && out_wr && (out_rd == rs1)));
  assign hit_b  = dec.uses_rs2 && (rs2 != '0) &&
                  (busy[rs2] || (full && out_wr && (out_rd == rs2)));
  assign hazard = hit_a || hit_b;

  assign in_ready = rst_n && (!full || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign handoff  = full && out_ready && !flush;

  scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (handoff && out_wr && (out_rd != '0)),
    .set_addr (out_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .busy     (busy)
  );

  // Next occupancy: flush empties, accept fills, a bare handoff drains.
  always_comb begin
    state_next = state;
    if (flush)        state_next = ST_EMPTY;
    else if (accept)  state_next = ST_FULL;
    else if (handoff) state_next = ST_EMPTY;
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Decode -> issue boundary: capture decoded fields and operands on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_rd      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
      out_wr      <= 1'b0;
    end else if (accept) begin
      out_opcode  <= dec.opcode;
      out_funct3  <= dec.funct3;
      out_funct7  <= dec.funct7;
      out_rd      <= rd;
      out_rs1_val <= rf_a;
      out_rs2_val <= rf_b;
      out_imm     <= imm_ext;
      out_pc      <= in_pc;
      out_illegal <= dec.illegal;
      out_wr      <= dec.writes_rd;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_decode_issue;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_ready;
  logic [XLEN-1:0] in_instr = '0, in_pc = '0;
  logic [4:0]      rf_addr_a, rf_addr_b;
  logic [XLEN-1:0] rf_a, rf_b;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic            flush = 1'b0;
  logic            out_valid, out_ready = 1'b0;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
  logic            out_illegal;

  logic [XLEN-1:0] regs [NREG];
  assign rf_a = regs[rf_addr_a];
  assign rf_b = regs[rf_addr_b];

  always #5 clk = ~clk;

  decode_issue #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_a(rf_a), .rf_b(rf_b), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_full;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_b, m_imm, m_pc;
  bit          m_ill, m_wr;
  bit          m_busy [NREG];

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit writes(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction
  function automatic bit use1(input logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit use2(input logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  // Immediate value as a signed integer offset, built arithmetically.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int off;
    off = 0;
    case (i[6:0])
      7'h37, 7'h17: off = i & 32'hFFFFF000;
      7'h67, 7'h03, 7'h13: begin
        off = i[31:20];
        if (i[31]) off = off - 4096;
      end
      7'h23: begin
        off = i[31:25] * 32 + i[11:7];
        if (i[31]) off = off - 4096;
      end
      7'h63: begin
        off = i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2;
        if (i[31]) off = off - 4096;
      end
      7'h6F: begin
        off = i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2;
        if (i[31]) off = off - (1 << 20);
      end
      default: off = 0;
    endcase
    return off;
  endfunction

  function automatic bit src_blocked(input logic [4:0] r);
    return (r != 0) && (m_busy[r] || (m_full && m_wr && m_rd == r));
  endfunction

  function automatic bit exp_ready();
    bit h;
    h = (use1(in_instr[6:0]) && src_blocked(in_instr[19:15])) ||
        (use2(in_instr[6:0]) && src_blocked(in_instr[24:20]));
    return rst_n && (!m_full || out_ready) && !h && !flush;
  endfunction

  function automatic bit m_acc();
    return in_valid && exp_ready();
  endfunction

  function automatic bit m_hand();
    return m_full && out_ready && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 0; m_op <= 0; m_f3 <= 0; m_f7 <= 0; m_rd <= 0;
      m_a <= 0; m_b <= 0; m_imm <= 0; m_pc <= 0; m_ill <= 0; m_wr <= 0;
      for (int k = 0; k < NREG; k++) m_busy[k] <= 0;
    end else begin
      if (wb_valid) m_busy[wb_addr] <= 0;
      if (m_hand() && m_wr && m_rd != 0) m_busy[m_rd] <= 1;
      if (flush)        m_full <= 0;
      else if (m_acc()) m_full <= 1;
      else if (m_hand()) m_full <= 0;
      if (m_acc()) begin
        m_op  <= in_instr[6:0];
        m_f3  <= in_instr[14:12];
        m_f7  <= in_instr[31:25];
        m_rd  <= in_instr[11:7];
        m_a   <= regs[in_instr[19:15]];
        m_b   <= regs[in_instr[24:20]];
        m_imm <= model_imm(in_instr);
        m_pc  <= in_pc;
        m_ill <= !legal(in_instr[6:0]);
        m_wr  <= writes(in_instr[6:0]);
      end
    end
  end

  // Compare DUT against model on the falling edge.
  always @(negedge clk) begin
    check("out_valid", out_valid, m_full);
    check("in_ready", in_ready, exp_ready());
    check("rf_addr_a", rf_addr_a, in_instr[19:15]);
    check("rf_addr_b", rf_addr_b, in_instr[24:20]);
    if (m_full) begin
      check("out_opcode", out_opcode, m_op);
      check("out_funct3", out_funct3, m_f3);
      check("out_funct7", out_funct7, m_f7);
      check("out_rd", out_rd, m_rd);
      check("out_rs1_val", out_rs1_val, m_a);
      check("out_rs2_val", out_rs2_val, m_b);
      check("out_imm", out_imm, m_imm);
      check("out_pc", out_pc, m_pc);
      check("out_illegal", out_illegal, m_ill);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr);
    in_instr = instr;
    in_pc    = $urandom & 32'hFFFFFFFC;
    in_valid = 1'b1;
  endtask

  task automatic wb_one(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    step();
    wb_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    int n;
    regs[0] = '0;
    for (int k = 1; k < NREG; k++) regs[k] = $urandom;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", dut.busy, 0);
    rst_n = 1'b1;

    // Immediates: lui, beq -4, sw -1
    out_ready = 1'b1;
    present(32'hFFFFF0B7);
    #1 check("first_accept_ready", in_ready, 1);
    step();
    check("lui_imm", out_imm, 32'hFFFFF000);
    check("lui_rd", out_rd, 1);
    present(32'hFE000EE3);
    step();
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    present(32'hFE002FA3);
    step();
    check("sw_imm", out_imm, 32'hFFFFFFFF);
    in_valid = 1'b0;
    step();
    check("lui_busy1", dut.busy[1], 1);
    wb_one(5'd1);

    // RAW: addi x5,x0,7 then add x6,x5,x5
    present(32'h00700293);
    step();
    present(32'h00528333);
    #1 check("raw_stage_stall", in_ready, 0);
    step();
    check("raw_sb_stall", in_ready, 0);
    step();
    check("raw_sb_stall2", in_ready, 0);
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    #1 check("wb_no_bypass", in_ready, 0);
    step();
    wb_valid = 1'b0;
    #1 check("accept_after_wb", in_ready, 1);
    step();
    check("add_valid", out_valid, 1);
    check("add_rd", out_rd, 6);
    check("add_rs1", out_rs1_val, regs[5]);
    in_valid = 1'b0;
    step();
    wb_one(5'd6);

    // Eight independent instructions back-to-back
    n = 0;
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1;
      if (i < 8) present((32'(i) << 20) | (32'(10 + i) << 7) | 32'h13);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) n++;
      if (i < 8) check("b2b_ready", in_ready, 1);
      step();
    end
    check("b2b_handoffs", n, 8);
    present(32'h00000A13);
    step();
    out_ready = 1'b0;
    present(32'h00000A93);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_rd", out_rd, 20);
      check("hold_imm", out_imm, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    for (int k = 10; k <= 21; k++) wb_one(5'(k));
    check("b2b_busy_clear", dut.busy, 0);

    // Flush while holding addi x9
    out_ready = 1'b0;
    present(32'h00100493);
    step();
    check("flush_pre_valid", out_valid, 1);
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_busy9", dut.busy[9], 0);
    step();
    check("flush_busy9_later", dut.busy[9], 0);
    present(32'h00000013);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("nop_busy0", dut.busy[0], 0);

    // Reset while FULL with out_ready low
    out_ready = 1'b1;
    present(32'h00000113);
    step();
    present(32'h00000193);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    check("prerst_busy2", dut.busy[2], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", dut.busy, 0);
    check("midrst_rd", out_rd, 0);
    check("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("postrst_ready", in_ready, 1);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 7) present(rand_instr());
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_addr   = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    in_valid = 1'b0;
    wb_valid = 1'b0;
    flush    = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter XLEN, default 32: data and instruction width.
REQ-002 Parameter NREG, default 32: architectural register count; register address width is $clog2(NREG).
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  fetch offers an instruction.
REQ-007 in_ready  out  1  stage accepts the instruction this cycle.
REQ-008 in_instr, in_pc  in  XLEN each  instruction word and its PC.
REQ-009 rf_addr_a, rf_addr_b  out  $clog2(NREG) each  register file read addresses (rs1, rs2).
REQ-010 rf_a, rf_b  in  XLEN each  asynchronous register file read data.
REQ-011 wb_valid, wb_addr  in  1, $clog2(NREG)  writeback retiring a write to wb_addr.
REQ-012 flush  in  1  discard the held instruction.
REQ-013 out_valid  out  1 / out_ready  in  1  downstream handshake.
REQ-014 out_opcode 7, out_funct3 3, out_funct7 7, out_rd $clog2(NREG)  out  decoded fields.
REQ-015 out_rs1_val, out_rs2_val, out_imm, out_pc  out  XLEN each  operands, sign-extended immediate, PC.
REQ-016 out_illegal  out  1  opcode is not RV32I.

Function
REQ-017 rf_addr_a/rf_addr_b SHALL be combinational from in_instr[19:15] and in_instr[24:20].
REQ-018 Stage states: EMPTY (out_valid=0) and FULL (out_valid=1); latency in->out is exactly 1 cycle.
REQ-019 Accept = in_valid && in_ready; on accept all out_* register the decoded fields and rf_a/rf_b, and state becomes FULL.
REQ-020 FULL->EMPTY on out_valid && out_ready without accept; FULL->FULL on handoff plus accept (back-to-back, one instruction per cycle).
REQ-021 in_ready = (EMPTY || out_ready) && !hazard && !flush.
REQ-022 hazard = an rs field actually used by in_instr's format, nonzero, matching a set scoreboard bit, or matching out_rd of a FULL stage whose instruction writes rd.
REQ-023 Scoreboard: NREG-bit vector; bit rd set on downstream handoff of an rd-writing instruction with rd!=0; bit 0 never set.
REQ-024 wb_valid clears bit wb_addr at the clock edge; no bypass: a same-cycle clear does not remove the hazard that cycle.
REQ-025 Simultaneous set and clear of the same bit: set wins.
REQ-026 flush: state becomes EMPTY next edge, no handoff occurs that cycle, scoreboard unchanged, no accept that cycle.
REQ-027 Immediates: I, S, B, U, J formats per RV32I, sign-extended to XLEN; R-type out_imm = 0.
REQ-028 Unknown opcode: out_illegal=1, treated as writing no rd, reads no rs.

Reset
REQ-029 rst_n low: state EMPTY, scoreboard all zero, every out_* register zero, regardless of handshake in progress.
REQ-030 in_ready SHALL be 0 while rst_n is low.
REQ-031 First accept possible on the first rising clk after rst_n deasserts.

Structure
REQ-032 Package riscv_pkg holds XLEN/NREG defaults, opcode enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP), immediate-format enum, and a decoded-instruction struct.
REQ-033 One sub-module, scoreboard: set/clear ports, NREG-bit busy vector output.
REQ-034 Immediate generation is a package function.

Verification
REQ-035 Reset mid-FULL with out_ready=0: out_valid=0, scoreboard=0 immediately, in_ready=1 after release.
REQ-036 addi x5,x0,7 then add x6,x5,x5 back-to-back, no wb: second stalls (in_ready=0) until wb_valid with wb_addr=5, accepted the cycle after.
REQ-037 wb_valid wb_addr=5 in the same cycle that add x6,x5,x5 issues with bit 5 set: stall that cycle, accept next.
REQ-038 lui x1,0xFFFFF -> out_imm=0xFFFFF000; beq offset -4 -> out_imm=0xFFFFFFFC; sw offset -1 -> 0xFFFFFFFF.
REQ-039 Eight independent instructions, out_ready=1: eight handoffs in eight consecutive cycles; out_ready low for 3 cycles: output held stable, in_ready=0.
REQ-040 flush with FULL holding addi x9: out_valid=0 next cycle, scoreboard bit 9 stays 0; addi x0,x0,0 never sets bit 0.
